// File: rtl/iob_arb_pkg.sv
// Shared types and constants for the IOb round-robin bus arbiter.
package iob_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEF = 255;
    localparam int ARB_MAX_DATA_W  = 1024;

    // Read data returned to a master whose transaction was killed by the watchdog.
    localparam logic [ARB_MAX_DATA_W-1:0] ARB_TIMEOUT_RDATA = '1;

    function automatic int arb_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/iob_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module iob_rr_select #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  mask_ge;
    logic [N-1:0]  req_hi;
    logic [IW-1:0] idx_hi;
    logic [IW-1:0] idx_lo;

    for (genvar i = 0; i < N; i++) begin : g_mask
        assign mask_ge[i] = (IW'(i) >= ptr);
    end

    assign req_hi = req & mask_ge;
    assign found  = |req;

    // Two lowest-index searches: one limited to [ptr..N-1], one over the whole vector for wrap.
    always_comb begin
        idx_hi = '0;
        idx_lo = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_hi[j]) idx_hi = IW'(j);
            if (req[j])    idx_lo = IW'(j);
        end
    end

    assign idx = (|req_hi) ? idx_hi : idx_lo;

endmodule

// File: rtl/iob_bus_arbiter.sv
// Round-robin arbiter sharing one IOb native slave between N_MASTERS requesters.
// Optional watchdog enabled by defining IOB_ARB_TIMEOUT_EN.
module iob_bus_arbiter
    import iob_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = ARB_TIMEOUT_DEF,
    localparam int IW       = $clog2(N_MASTERS),
    localparam int SW       = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0] m_address,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [N_MASTERS*SW-1:0]   m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0] m_rdata,
    output logic [N_MASTERS-1:0]      m_ready,
    output logic                      s_valid,
    output logic [ADDR_W-1:0]         s_address,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [SW-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic                      s_ready,
    output logic [IW-1:0]             grant,
    output logic                      timeout_err
);

    logic [N_MASTERS-1:0][ADDR_W-1:0] addr_a;
    logic [N_MASTERS-1:0][DATA_W-1:0] wdata_a;
    logic [N_MASTERS-1:0][DATA_W-1:0] rdata_a;
    logic [N_MASTERS-1:0][SW-1:0]     wstrb_a;

    assign addr_a  = m_address;
    assign wdata_a = m_wdata;
    assign wstrb_a = m_wstrb;
    assign m_rdata = rdata_a;

    arb_state_e        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     pick;
    logic              found;
    logic              busy;
    logic              g_valid;
    logic              done;
    logic              tmo_hit;
    logic              fin;
    logic [DATA_W-1:0] ret_data;

    iob_rr_select #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_sel (
        .req   (m_valid),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // Reset is folded into busy so a reset cycle in BUSY cannot complete the transfer.
    assign busy     = (state == ARB_BUSY) && rst;
    assign g_valid  = m_valid[grant];
    assign done     = busy && g_valid && s_ready;
    assign fin      = done || tmo_hit;
    assign ret_data = tmo_hit ? ARB_TIMEOUT_RDATA[DATA_W-1:0] : s_rdata;

    assign s_valid   = busy && g_valid && !tmo_hit;
    assign s_address = busy ? addr_a[grant]  : '0;
    assign s_wdata   = busy ? wdata_a[grant] : '0;
    assign s_wstrb   = busy ? wstrb_a[grant] : '0;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_resp
        assign m_ready[i] = fin && (grant == IW'(i));
        assign rdata_a[i] = m_ready[i] ? ret_data : '0;
    end

`ifdef IOB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          tmo_flag;

    // cnt is 0 in the first BUSY cycle, so the watchdog fires in BUSY cycle TIMEOUT.
    assign tmo_hit     = busy && g_valid && !s_ready && (cnt == CW'(TIMEOUT - 1));
    assign timeout_err = tmo_flag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == ARB_IDLE) cnt <= '0;
            else                   cnt <= cnt + CW'(1);
            if (tmo_hit) tmo_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (fin) begin
                        ptr   <= IW'(arb_next_idx(int'(grant), N_MASTERS));
                        state <= ARB_IDLE;
                    end else if (!g_valid) begin
                        // Abort: requester withdrew, keep its priority.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Self-checking bench for iob_bus_arbiter: directed plan steps plus randomized traffic vs. a reference model.
module tb_iob_bus_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;
    localparam int IW  = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      m_valid = '0;
    logic [N*AW-1:0]   m_address;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N*DW-1:0]   m_rdata;
    logic [N-1:0]      m_ready;
    logic              s_valid;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [DW-1:0]     s_rdata = '0;
    logic              s_ready = 1'b0;
    logic [IW-1:0]     grant;
    logic              timeout_err;

    logic [AW-1:0] a_addr  [N];
    logic [DW-1:0] a_wdata [N];
    logic [SW-1:0] a_wstrb [N];

    always #5 clk = ~clk;

    always_comb begin
        m_address = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        for (int i = 0; i < N; i++) begin
            m_address[i*AW +: AW] = a_addr[i];
            m_wdata[i*DW +: DW]   = a_wdata[i];
            m_wstrb[i*SW +: SW]   = a_wstrb[i];
        end
    end

    iob_bus_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .s_valid     (s_valid),
        .s_address   (s_address),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .s_ready     (s_ready),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the bus this cycle (-1 = nobody), rotation start, last grant.
    int owner = -1;
    int mptr  = 0;
    int lastg = 0;
    int bcnt  = 0;
    int lat   = 0;
    bit merr  = 1'b0;
    bit newg  = 1'b0;

    logic [N-1:0]  seen_ready = '0;
    logic [DW-1:0] obs_rdata [N];
    logic          obs_sv;
    logic [AW-1:0] obs_sa;
    logic [DW-1:0] obs_sw;
    logic [SW-1:0] obs_ss;
    logic [IW-1:0] obs_grant;
    logic          obs_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_m(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        a_addr[i]  = a;
        a_wdata[i] = d;
        a_wstrb[i] = s;
        m_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        m_valid    = '0;
        s_ready    = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        owner      = -1;
        mptr       = 0;
        lastg      = 0;
        bcnt       = 0;
        merr       = 1'b0;
        newg       = 1'b0;
        seen_ready = '0;
    endtask

    // One clock: compare DUT against model at negedge, then advance the model across posedge.
    task automatic tick();
        logic [N-1:0] er;
        logic gv, dn, tm;
        int o;
        @(negedge clk);
        er = '0; gv = 1'b0; dn = 1'b0; tm = 1'b0;
        o  = (owner < 0) ? 0 : owner;
        if (owner >= 0) begin
            gv = m_valid[owner];
            dn = gv && s_ready;
`ifdef IOB_ARB_TIMEOUT_EN
            tm = gv && !s_ready && (bcnt == TMO - 1);
`endif
            if (dn || tm) er[owner] = 1'b1;
        end
        chk("s_valid",   s_valid,   (owner >= 0) && gv && !tm);
        chk("s_address", s_address, (owner >= 0) ? a_addr[o]  : '0);
        chk("s_wdata",   s_wdata,   (owner >= 0) ? a_wdata[o] : '0);
        chk("s_wstrb",   s_wstrb,   (owner >= 0) ? a_wstrb[o] : '0);
        chk("m_ready",   m_ready,   er);
        for (int i = 0; i < N; i++) begin
            obs_rdata[i] = m_rdata[i*DW +: DW];
            chk("m_rdata", obs_rdata[i], er[i] ? (tm ? {DW{1'b1}} : s_rdata) : '0);
        end
        chk("grant", grant, lastg);
        chk("timeout_err", timeout_err, merr);
        seen_ready = m_ready;
        obs_sv     = s_valid;
        obs_sa     = s_address;
        obs_sw     = s_wdata;
        obs_ss     = s_wstrb;
        obs_grant  = grant;
        obs_err    = timeout_err;
        if (owner < 0) begin
            if (pick() >= 0) begin
                owner = pick();
                lastg = owner;
                bcnt  = 0;
                newg  = 1'b1;
            end
        end else if (dn || tm) begin
            mptr  = (owner + 1) % N;
            if (tm) merr = 1'b1;
            owner = -1;
        end else if (!gv) begin
            owner = -1;
        end else begin
            bcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        for (int i = 0; i < N; i++) begin
            if (seen_ready[i]) m_valid[i] = 1'b0;
            else if (!m_valid[i]) begin
                if ($urandom_range(0, 2) == 0)
                    set_m(i, $urandom, $urandom, SW'($urandom));
            end else if (owner == i && $urandom_range(0, 19) == 0) begin
                m_valid[i] = 1'b0;
            end
        end
        s_rdata = $urandom;
        if (owner < 0) begin
            s_ready = ($urandom_range(0, 3) == 0);
        end else begin
            if (newg) begin
`ifdef IOB_ARB_TIMEOUT_EN
                lat = ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(0, 3);
`else
                lat = $urandom_range(0, 3);
`endif
            end
            s_ready = m_valid[owner] && (bcnt == lat);
        end
        newg = 1'b0;
    endtask

    initial begin
        int ng, c0, c1, k;
        int gexp [4];
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_wstrb[i] = '0;
        end

        // Reset state
        do_reset();
        tick();
        chk("rst_grant", obs_grant, 0);
        chk("rst_err",   obs_err,   0);

        // Master 0 read, slave ready two cycles after s_valid
        set_m(0, 32'h100, 32'h0, 4'h0);
        tick();
        chk("t1_c0_svalid", obs_sv, 0);
        tick();
        chk("t1_c1_svalid", obs_sv, 1);
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        tick();
        chk("t1_ready0", seen_ready[0], 1);
        chk("t1_rdata0", obs_rdata[0], 32'h1234_5678);
        chk("t1_ready1", seen_ready[1], 0);
        s_ready = 1'b0; m_valid = '0;
        tick();

        // Two masters compete for four transactions from reset
        do_reset();
        set_m(0, 32'h200, 32'h11, 4'h0);
        set_m(1, 32'h300, 32'h22, 4'h0);
        gexp = '{0, 1, 0, 1};
        ng = 0; c0 = 0; c1 = 0; k = 0;
        while (ng < 4 && k < 40) begin
            s_ready = (owner >= 0);
            tick();
            k++;
            if (seen_ready != '0) begin
                chk("t2_grant", obs_grant, gexp[ng]);
                ng++;
                if (seen_ready[0]) c0++;
                if (seen_ready[1]) c1++;
            end
            m_valid[0] = !seen_ready[0];
            m_valid[1] = !seen_ready[1];
        end
        chk("t2_done", ng, 4);
        chk("t2_cnt0", c0, 2);
        chk("t2_cnt1", c1, 2);
        m_valid = '0; s_ready = 1'b0;
        tick();

        // Master 1 write while master 0 idle
        set_m(1, 32'h10, 32'hA5, 4'hF);
        tick();
        s_ready = 1'b1;
        tick();
        chk("t3_addr",  obs_sa, 32'h10);
        chk("t3_wdata", obs_sw, 32'hA5);
        chk("t3_wstrb", obs_ss, 4'hF);
        chk("t3_ready", seen_ready[1], 1);
        s_ready = 1'b0; m_valid = '0;
        tick();
        set_m(0, 32'h400, 32'h0, 4'h0);
        set_m(1, 32'h500, 32'h0, 4'h0);
        tick();
        tick();
        chk("t3_next_grant", obs_grant, 0);
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0; m_valid = '0;
        tick();

        // Abort in second BUSY cycle keeps priority
        do_reset();
        set_m(0, 32'h600, 32'h0, 4'h0);
        tick();
        tick();
        m_valid[0] = 1'b0;
        tick();
        chk("t4_abort_svalid", obs_sv, 0);
        chk("t4_abort_ready",  seen_ready, 0);
        tick();
        chk("t4_idle_ready", seen_ready, 0);
        set_m(0, 32'h600, 32'h0, 4'h0);
        set_m(1, 32'h700, 32'h0, 4'h0);
        tick();
        tick();
        chk("t4_prio", obs_grant, 0);
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0; m_valid = '0;
        tick();

`ifdef IOB_ARB_TIMEOUT_EN
        // Slave never answers: watchdog completes in BUSY cycle TMO
        do_reset();
        set_m(0, 32'h800, 32'h0, 4'h0);
        tick();
        k = 0;
        while (!seen_ready[0] && k < 20) begin
            tick();
            k++;
        end
        chk("t5_tmo_cycle", k, TMO);
        chk("t5_tmo_rdata", obs_rdata[0], 32'hFFFF_FFFF);
        m_valid = '0;
        tick();
        chk("t5_err_set", obs_err, 1);
        tick();
        tick();
        chk("t5_err_sticky", obs_err, 1);
        do_reset();
        tick();
        chk("t5_err_clr", obs_err, 0);
`else
        // No watchdog: a silent slave stalls the bus indefinitely
        do_reset();
        set_m(0, 32'h800, 32'h0, 4'h0);
        tick();
        repeat (30) tick();
        chk("t5_stall_svalid", obs_sv, 1);
        chk("t5_stall_err",    obs_err, 0);
        s_ready = 1'b1;
        tick();
        chk("t5_late_ready", seen_ready[0], 1);
        s_ready = 1'b0; m_valid = '0;
        tick();
`endif

        // Reset while BUSY abandons the transfer
        do_reset();
        set_m(2, 32'h900, 32'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0; s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_rst_no_ready", m_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; s_ready = 1'b0; m_valid = '0;
        owner = -1; mptr = 0; lastg = 0; bcnt = 0; merr = 1'b0; newg = 1'b0;
        tick();
        chk("t6_svalid", obs_sv, 0);
        chk("t6_grant",  obs_grant, 0);
        chk("t6_ready",  seen_ready, 0);

        // Randomized traffic against the model
        do_reset();
        repeat (3000) begin
            drive_rand();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
